// File: rtl/btn4_debounce_pkg.sv
// btn4_pkg: shared definitions for the four-channel push-button conditioner.
//   DCNT_W  - width of the per-channel debounce counter
//   RCNT_W  - width of the per-channel auto-repeat counter
//   NCH     - number of button channels
//   btn_state_t - per-channel press FSM encoding
package btn4_pkg;

  localparam int DCNT_W = 8;
  localparam int RCNT_W = 12;
  localparam int NCH    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

endpackage

// File: rtl/btn4_debounce_if.sv
// btn4_debounce_if: button bundle between the raw pins, the 1 ms tick source
// and the conditioner.
//   ce        - 1 ms clock-enable, one clk wide
//   BTN       - raw asynchronous buttons, active-high
//   BTN_LVL   - debounced level per channel
//   BTN_PULSE - one-clk pulse per accepted press and per repeat
// Modports: master drives ce/BTN and observes the outputs; slave is the
// conditioner.
interface btn4_debounce_if;

  logic                      ce;
  logic [btn4_pkg::NCH-1:0]  BTN;
  logic [btn4_pkg::NCH-1:0]  BTN_LVL;
  logic [btn4_pkg::NCH-1:0]  BTN_PULSE;

  modport master (output ce, output BTN, input BTN_LVL, input BTN_PULSE);
  modport slave  (input ce, input BTN, output BTN_LVL, output BTN_PULSE);

endinterface

// File: rtl/btn_deb_ch.sv
// btn_deb_ch: one push-button channel.
//   2-flop synchroniser -> debounce counter on ce -> press FSM with optional
//   auto-repeat. Macro BTN_AUTOREPEAT_EN compiles in the repeat counter and the
//   REPEAT state; without it a held button yields a single press pulse.
// Ports:
//   clk, rst - system clock, synchronous active-high reset
//   ce       - 1 ms tick
//   btn      - raw button input
//   lvl      - debounced level (registered)
//   pulse    - one-clk press / repeat pulse (registered)
//
// state  | meaning
// IDLE   | button released, waiting for debounced rise
// HELD   | pressed, counting the initial repeat delay
// REPEAT | pressed, emitting a pulse every REP_RATE_MS ticks
module btn_deb_ch
  import btn4_pkg::*;
#(
  parameter int DEB_MS       = 20,
  parameter int REP_DELAY_MS = 500,
  parameter int REP_RATE_MS  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic btn,
  output logic lvl,
  output logic pulse
);

  localparam logic [DCNT_W-1:0] DEB_TC = DCNT_W'(DEB_MS - 1);

  logic              s1, s2;
  logic [DCNT_W-1:0] dcnt;
  logic              deb_hit, rise, fall;
  btn_state_t        state, state_n;
  logic              pulse_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      dcnt <= '0;
      lvl  <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == lvl) begin
        dcnt <= '0;
      end else if (ce) begin
        if (dcnt == DEB_TC) begin
          lvl  <= s2;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end
  end

  // Same condition that flips lvl this cycle, so the FSM and pulse register
  // update on the very edge where lvl changes.
  assign deb_hit = (s2 != lvl) && ce && (dcnt == DEB_TC);
  assign rise    = deb_hit & s2;
  assign fall    = deb_hit & ~s2;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [RCNT_W-1:0] DLY_TC  = RCNT_W'(REP_DELAY_MS - 1);
  localparam logic [RCNT_W-1:0] RATE_TC = RCNT_W'(REP_RATE_MS - 1);

  logic [RCNT_W-1:0] rcnt, rcnt_n;
`else
  // Repeat timing has no effect when auto-repeat is compiled out.
  logic unused_rep;
  assign unused_rep = ^{REP_DELAY_MS, REP_RATE_MS};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rcnt  <= '0;
`endif
    end else begin
      state <= state_n;
      pulse <= pulse_n;
`ifdef BTN_AUTOREPEAT_EN
      rcnt  <= rcnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    pulse_n = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rcnt_n  = rcnt;
`endif
    if (fall) begin
      // release wins over any pending repeat in the same cycle
      state_n = IDLE;
`ifdef BTN_AUTOREPEAT_EN
      rcnt_n  = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_n = HELD;
            pulse_n = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_n  = '0;
`endif
          end
        end
        HELD: begin
`ifdef BTN_AUTOREPEAT_EN
          if (ce) begin
            if (rcnt == DLY_TC) begin
              pulse_n = 1'b1;
              rcnt_n  = '0;
              state_n = REPEAT;
            end else begin
              rcnt_n = rcnt + 1'b1;
            end
          end
`else
          state_n = HELD;
`endif
        end
`ifdef BTN_AUTOREPEAT_EN
        REPEAT: begin
          if (ce) begin
            if (rcnt == RATE_TC) begin
              pulse_n = 1'b1;
              rcnt_n  = '0;
            end else begin
              rcnt_n = rcnt + 1'b1;
            end
          end
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn4_debounce.sv
// btn4_debounce: four independent push-button conditioners for the digit
// up/down counters. Each channel is synchronised, debounced on the 1 ms ce
// tick and produces a clean level plus a single-clk press pulse.
// Optional auto-repeat: define BTN_AUTOREPEAT_EN.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - btn4_debounce_if.slave (ce, BTN in; BTN_LVL, BTN_PULSE out)
// Parameters: DEB_MS (1..255), REP_DELAY_MS (1..4095), REP_RATE_MS (1..4095).
module btn4_debounce
  import btn4_pkg::*;
#(
  parameter int DEB_MS       = 20,
  parameter int REP_DELAY_MS = 500,
  parameter int REP_RATE_MS  = 100
) (
  input  logic            clk,
  input  logic            rst,
  btn4_debounce_if.slave  bus
);

  logic [NCH-1:0] lvl_w;
  logic [NCH-1:0] pulse_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    btn_deb_ch #(
      .DEB_MS       (DEB_MS),
      .REP_DELAY_MS (REP_DELAY_MS),
      .REP_RATE_MS  (REP_RATE_MS)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .ce    (bus.ce),
      .btn   (bus.BTN[i]),
      .lvl   (lvl_w[i]),
      .pulse (pulse_w[i])
    );
  end

  assign bus.BTN_LVL   = lvl_w;
  assign bus.BTN_PULSE = pulse_w;

endmodule

// File: tb/tb_btn4_debounce.sv
// Directed bench for btn4_debounce with DEB_MS=4, REP_DELAY_MS=10,
// REP_RATE_MS=3 and ce high on every 4th clk edge (edges whose index is a
// multiple of 4). Edge index = number of rising clk edges so far (cyc).
module tb_btn4_debounce;

  localparam int DEB  = 4;
  localparam int DLY  = 10;
  localparam int RATE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int ch;
    int cyc;
  } ev_t;
  ev_t evq[$];

  btn4_debounce_if bus ();

  btn4_debounce #(
    .DEB_MS       (DEB),
    .REP_DELAY_MS (DLY),
    .REP_RATE_MS  (RATE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.ce = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1 bus.ce = ((cyc + 1) % 4 == 0);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.BTN_PULSE[i] === 1'b1) evq.push_back('{ch: i, cyc: cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic goto(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  task automatic align4();
    step(1);
    while (cyc % 4 != 0) step(1);
  endtask

  function automatic int ev_count(input int ch);
    int n = 0;
    foreach (evq[k]) if (evq[k].ch == ch) n++;
    return n;
  endfunction

  function automatic int ev_nth(input int ch, input int idx);
    int n = 0;
    foreach (evq[k]) begin
      if (evq[k].ch == ch) begin
        if (n == idx) return evq[k].cyc;
        n++;
      end
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.BTN = 4'hF;
    step(12);
    checks++;
    if (bus.BTN_LVL !== 4'b0000) begin
      errors++;
      $display("FAIL reset_lvl: got %b want 0000", bus.BTN_LVL);
    end
    checks++;
    if (bus.BTN_PULSE !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulse: got %b want 0000", bus.BTN_PULSE);
    end
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL reset_no_pulse: got %0d pulses want 0", evq.size());
    end
    bus.BTN = 4'h0;
    step(2);
    rst = 1'b0;
    step(4);
  endtask

  task automatic test_clean_press();
    int e0;
    align4();
    e0 = cyc;
    evq.delete();
    bus.BTN[0] = 1'b1;
    goto(e0 + 15);
    checks++;
    if (bus.BTN_LVL[0] !== 1'b0) begin
      errors++;
      $display("FAIL press_lvl_early: got %b want 0", bus.BTN_LVL[0]);
    end
    goto(e0 + 16);
    checks++;
    if (bus.BTN_PULSE !== 4'b0001) begin
      errors++;
      $display("FAIL press_pulse: got %b want 0001", bus.BTN_PULSE);
    end
    checks++;
    if (bus.BTN_LVL !== 4'b0001) begin
      errors++;
      $display("FAIL press_lvl: got %b want 0001", bus.BTN_LVL);
    end
    goto(e0 + 17);
    checks++;
    if (bus.BTN_PULSE !== 4'b0000) begin
      errors++;
      $display("FAIL press_pulse_width: got %b want 0000", bus.BTN_PULSE);
    end
    goto(e0 + 32);
    bus.BTN[0] = 1'b0;
    goto(e0 + 47);
    checks++;
    if (bus.BTN_LVL[0] !== 1'b1) begin
      errors++;
      $display("FAIL release_lvl_early: got %b want 1", bus.BTN_LVL[0]);
    end
    goto(e0 + 48);
    checks++;
    if (bus.BTN_LVL !== 4'b0000) begin
      errors++;
      $display("FAIL release_lvl: got %b want 0000", bus.BTN_LVL);
    end
    goto(e0 + 60);
    checks++;
    if (evq.size() != 1 || ev_nth(0, 0) != e0 + 16) begin
      errors++;
      $display("FAIL press_single: got %0d pulses first at %0d want 1 at %0d",
               evq.size(), ev_nth(0, 0), e0 + 16);
    end
  endtask

  task automatic test_bounce();
    int e0;
    align4();
    e0 = cyc;
    evq.delete();
    for (int k = 0; k < 14; k++) begin
      goto(e0 + 3 * k);
      bus.BTN[1] = (k % 2 == 0);
    end
    goto(e0 + 40);
    bus.BTN[1] = 1'b1;
    goto(e0 + 55);
    checks++;
    if (ev_count(1) != 0) begin
      errors++;
      $display("FAIL bounce_no_pulse: got %0d pulses want 0", ev_count(1));
    end
    checks++;
    if (bus.BTN_LVL[1] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_lvl_early: got %b want 0", bus.BTN_LVL[1]);
    end
    goto(e0 + 56);
    checks++;
    if (bus.BTN_PULSE !== 4'b0010) begin
      errors++;
      $display("FAIL bounce_pulse: got %b want 0010", bus.BTN_PULSE);
    end
    goto(e0 + 60);
    bus.BTN[1] = 1'b0;
    goto(e0 + 80);
    checks++;
    if (ev_count(1) != 1 || bus.BTN_LVL !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_settle: got %0d pulses lvl %b want 1 pulses lvl 0000",
               ev_count(1), bus.BTN_LVL);
    end
  endtask

  task automatic test_autorepeat();
    int e0, p, n_exp, exp_c;
    align4();
    e0 = cyc;
    p  = e0 + 16;
    evq.delete();
    bus.BTN[2] = 1'b1;
    goto(e0 + 120);
    bus.BTN[2] = 1'b0;
    goto(e0 + 144);
`ifdef BTN_AUTOREPEAT_EN
    n_exp = 8;
`else
    n_exp = 1;
`endif
    checks++;
    if (ev_count(2) != n_exp || evq.size() != n_exp) begin
      errors++;
      $display("FAIL repeat_count: got %0d pulses want %0d", evq.size(), n_exp);
    end
    for (int n = 0; n < n_exp; n++) begin
      exp_c = (n == 0) ? p : p + 4 * DLY + 4 * RATE * (n - 1);
      checks++;
      if (ev_nth(2, n) != exp_c) begin
        errors++;
        $display("FAIL repeat_time[%0d]: got cyc %0d want cyc %0d", n, ev_nth(2, n), exp_c);
      end
    end
    checks++;
    if (bus.BTN_LVL !== 4'b0000) begin
      errors++;
      $display("FAIL repeat_release_lvl: got %b want 0000", bus.BTN_LVL);
    end
  endtask

  task automatic test_simultaneous();
    int e0;
    align4();
    e0 = cyc;
    evq.delete();
    bus.BTN = 4'b1111;
    goto(e0 + 15);
    checks++;
    if (bus.BTN_PULSE !== 4'b0000) begin
      errors++;
      $display("FAIL all4_pulse_early: got %b want 0000", bus.BTN_PULSE);
    end
    goto(e0 + 16);
    checks++;
    if (bus.BTN_PULSE !== 4'b1111) begin
      errors++;
      $display("FAIL all4_pulse: got %b want 1111", bus.BTN_PULSE);
    end
    checks++;
    if (bus.BTN_LVL !== 4'b1111) begin
      errors++;
      $display("FAIL all4_lvl: got %b want 1111", bus.BTN_LVL);
    end
    goto(e0 + 17);
    checks++;
    if (bus.BTN_PULSE !== 4'b0000) begin
      errors++;
      $display("FAIL all4_pulse_width: got %b want 0000", bus.BTN_PULSE);
    end
    goto(e0 + 20);
    bus.BTN = 4'b0000;
    goto(e0 + 40);
    checks++;
    if (bus.BTN_LVL !== 4'b0000 || evq.size() != 4) begin
      errors++;
      $display("FAIL all4_release: got lvl %b %0d pulses want lvl 0000 4 pulses",
               bus.BTN_LVL, evq.size());
    end
  endtask

  task automatic test_reset_mid_press();
    int e0, e1;
    align4();
    e0 = cyc;
    e1 = e0 + 24;
    evq.delete();
    bus.BTN[0] = 1'b1;
    goto(e1);
    bus.BTN[3] = 1'b1;
    goto(e1 + 8);
    rst = 1'b1;
    goto(e1 + 9);
    checks++;
    if (bus.BTN_LVL !== 4'b0000 || bus.BTN_PULSE !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_outputs: got lvl %b pulse %b want 0000 0000",
               bus.BTN_LVL, bus.BTN_PULSE);
    end
    goto(e1 + 12);
    rst = 1'b0;
    goto(e1 + 27);
    checks++;
    if (bus.BTN_LVL !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_lvl_early: got %b want 0000", bus.BTN_LVL);
    end
    goto(e1 + 28);
    checks++;
    if (bus.BTN_PULSE !== 4'b1001) begin
      errors++;
      $display("FAIL midrst_pulse: got %b want 1001", bus.BTN_PULSE);
    end
    checks++;
    if (bus.BTN_LVL !== 4'b1001) begin
      errors++;
      $display("FAIL midrst_lvl: got %b want 1001", bus.BTN_LVL);
    end
    goto(e1 + 32);
    bus.BTN = 4'b0000;
    goto(e1 + 52);
    checks++;
    if (ev_count(3) != 1 || ev_nth(3, 0) != e1 + 28 || ev_count(0) != 2) begin
      errors++;
      $display("FAIL midrst_events: got ch3 %0d at %0d ch0 %0d want ch3 1 at %0d ch0 2",
               ev_count(3), ev_nth(3, 0), ev_count(0), e1 + 28);
    end
    checks++;
    if (bus.BTN_LVL !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_release: got %b want 0000", bus.BTN_LVL);
    end
  endtask

  initial begin
    bus.BTN = 4'b0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_autorepeat();
    test_simultaneous();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn4_debounce.md
# btn4_debounce

Four-channel push-button conditioner between the raw `BTN[3:0]` pins and the digit up/down counters of the square-root calculator. Each channel is synchronised to `clk` and debounced on the 1 ms clock-enable `ce` produced by the display scanner. Each channel outputs a clean level and a single-cycle press pulse, so each physical press steps a counter exactly once. An optional auto-repeat turns a held button into a periodic pulse train for fast digit entry.

## Interface
- `DEB_MS`, 20: number of consecutive `ce` ticks an input must hold a new value before the stable level changes. Range 1..255.
- `REP_DELAY_MS`, 500: `ce` ticks from the press pulse to the first repeat pulse. Range 1..4095.
- `REP_RATE_MS`, 100: `ce` ticks between later repeat pulses. Range 1..4095.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ce` in 1: 1 ms tick, one `clk` wide.
- `BTN` in 4: raw, asynchronous button inputs, active-high.
- `BTN_LVL` out 4: debounced level per channel.
- `BTN_PULSE` out 4: one-`clk` pulse per accepted press and per repeat.

## Operation
- Input synchronisation:
  - Each channel passes through a 2-flop synchroniser. Call its output `s`.
  - The synchroniser flops reset to 0.
- Debounce:
  - Each channel has an 8-bit counter `dcnt` and a stable level `lvl`, which drives `BTN_LVL`.
  - When `s == lvl`, `dcnt` clears to 0 on every `clk`, whether or not `ce` is high.
  - When `s != lvl` and `ce = 1`:
    - if `dcnt == DEB_MS-1`, then `lvl <= s` and `dcnt <= 0`;
    - otherwise `dcnt` increments.
  - A single glitch that lasts less than one `ce` period therefore restarts the count.
- Per-channel FSM, states IDLE, HELD, REPEAT:
  - IDLE → HELD: on the edge where `lvl` goes 0→1. `BTN_PULSE[i]` is asserted for that same cycle, registered together with `lvl`. `rcnt` clears to 0.
  - HELD (auto-repeat enabled only):
    - `rcnt` increments on each `ce`;
    - when `ce` is high and `rcnt == REP_DELAY_MS-1`: pulse, `rcnt <= 0`, go to REPEAT.
  - REPEAT:
    - when `ce` is high and `rcnt == REP_RATE_MS-1`: pulse, `rcnt <= 0`;
    - otherwise `rcnt` increments on `ce`.
  - Any state → IDLE on the edge where `lvl` goes 1→0. No pulse is generated on release, and `rcnt` clears.
- `rcnt` is 12 bits wide and never wraps. It is compared for equality only and cleared whenever it matches.
- Channels are fully independent. Simultaneous presses on several channels produce pulses in the same cycle.
- Reset:
  - `BTN_LVL = 4'b0000`, `BTN_PULSE = 4'b0000`, all counters 0, all FSMs in IDLE.
  - Reset in the middle of a press or a repeat takes priority over everything.
  - A button still held when reset is released is accepted as a new press after 2 `clk` + `DEB_MS` ticks.

## Timing
- Latency from a clean `BTN` rise to `BTN_PULSE`:
  - 2 `clk` for synchronisation;
  - then `DEB_MS` `ce` ticks. The pulse fires on the `clk` edge where the `DEB_MS`-th qualifying `ce` is high.
- `BTN_LVL` and `BTN_PULSE` rise on the same edge. `BTN_PULSE` is always exactly 1 `clk` wide.
- First repeat arrives `REP_DELAY_MS` ticks after the press pulse. Later repeats follow every `REP_RATE_MS` ticks.
- If `ce` is held high continuously, every `clk` counts as a tick. This is legal, for simulation only.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `BTN_AUTOREPEAT_EN`:
  - Defined: HELD and REPEAT behave as described above.
  - Undefined: the FSM stays in HELD until release, no repeat pulses are produced, and the `rcnt` logic and the REPEAT state are not compiled.
  - Debounce and press-pulse behaviour are the same in both builds.

## Structure
- Package `btn4_pkg`:
  - FSM state encoding (IDLE = 2'd0, HELD = 2'd1, REPEAT = 2'd2);
  - `DCNT_W = 8`, `RCNT_W = 12`.
- Sub-module `btn_deb_ch`:
  - one channel: synchroniser, debounce counter, FSM, repeat counter;
  - the top instantiates it 4 times, with a generate loop over the channels.

## Test plan
All scenarios use `DEB_MS=4`, `REP_DELAY_MS=10`, `REP_RATE_MS=3`, and `ce` every 4 `clk`.
- Clean press on `BTN[0]`, held 8 ticks then released → `BTN_LVL[0]` rises and exactly one `BTN_PULSE[0]` fires 4 ticks after synchronisation. `BTN_LVL[0]` falls 4 ticks after release, with no release pulse.
- Bounce: `BTN[1]` toggles every 3 `clk` for 40 `clk`, then settles at 1 → no pulse during the bounce, then one pulse 4 ticks after settling.
- Hold `BTN[2]` for 30 ticks with `BTN_AUTOREPEAT_EN` defined → pulses at press, press+10, press+13, press+16, and so on. Without the macro → a single pulse.
- `BTN = 4'b1111` pressed in the same cycle → `BTN_PULSE = 4'b1111` for one cycle.
- `rst` asserted 2 ticks into a debounce on `BTN[3]` → all outputs 0 on the next edge. After reset is released with the button still held → one pulse 2 `clk` + 4 ticks later.
